multdiv_controller: RTL

//   Sequences the shared iterative multdiv unit for the X stage. Latches operands on issue, fires a
//   one-cycle ctrl_MULT/ctrl_DIV start pulse, holds the pipeline stalled until the result is ready,

---
 rtl/multdiv_controller.sv | 135 +++++++++++++
 1 files changed

// File: rtl/multdiv_controller.sv
// Sequencer for the shared iterative multdiv unit in the X stage. It latches the operands, sends a
// start pulse, stalls the pipe until the result arrives, then presents the result for one cycle.
module multdiv_controller #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int MULT_RSTATUS   = 4,
    parameter int DIV_RSTATUS    = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic        issue_is_div,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic        flush,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_resultRDY,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    output logic        stall,
    output logic        done_valid,
    output logic [31:0] result,
    output logic        exception,
    output logic [31:0] rstatus
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] COUNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, START, WAIT, DONE, DRAIN} state_t;

    state_t        state;
    logic          op_div;
    logic [CW-1:0] count;
    logic          timeout_pending;
    logic          done_r;
    logic [31:0]   exc_code;

    // The exception code follows the op that was latched, not whatever is sitting in X now.
    assign exc_code = op_div ? 32'(DIV_RSTATUS) : 32'(MULT_RSTATUS);

    // NOTE: stall and done_valid must react to issue_valid/flush in the same cycle, so they are
    // decoded from the registered state rather than registered themselves.
    assign stall = ((state == IDLE) && issue_valid && !flush) || (state == START) ||
                   (state == WAIT) || ((state == DRAIN) && issue_valid);
    assign done_valid = done_r && !flush;

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            op_div          <= 1'b0;
            count           <= '0;
            timeout_pending <= 1'b0;
            done_r          <= 1'b0;
            ctrl_MULT       <= 1'b0;
            ctrl_DIV        <= 1'b0;
            md_a            <= '0;
            md_b            <= '0;
            result          <= '0;
            exception       <= 1'b0;
            rstatus         <= '0;
        end else begin
            // NOTE: pulse-type outputs default low here with non-blocking assignments; the state
            // branches below only override them in the cycle they should fire.
            ctrl_MULT <= 1'b0;
            ctrl_DIV  <= 1'b0;
            done_r    <= 1'b0;
            result    <= '0;
            exception <= 1'b0;
            rstatus   <= '0;

            unique case (state)
                IDLE: begin
                    if (issue_valid && !flush) begin
                        op_div          <= issue_is_div;
                        md_a            <= operand_a;
                        md_b            <= operand_b;
                        timeout_pending <= 1'b0;
                        if (issue_is_div && operand_b == 32'd0) begin
                            state     <= DONE;
                            done_r    <= 1'b1;
                            exception <= 1'b1;
                            rstatus   <= 32'(DIV_RSTATUS);
                        end else begin
                            state     <= START;
                            ctrl_MULT <= !issue_is_div;
                            ctrl_DIV  <= issue_is_div;
                        end
                    end
                end
                START: begin
                    count <= '0;
                    state <= flush ? DRAIN : WAIT;
                end
                WAIT: begin
                    if (flush) begin
                        // A result landing with the flush means the unit is already free.
                        state <= md_resultRDY ? IDLE : DRAIN;
                        count <= '0;
                    end else if (md_resultRDY) begin
                        state     <= DONE;
                        done_r    <= 1'b1;
                        exception <= md_exception;
                        result    <= md_exception ? 32'd0 : md_result;
                        rstatus   <= md_exception ? exc_code : 32'd0;
                    end else if (count == COUNT_LAST) begin
                        state           <= DONE;
                        done_r          <= 1'b1;
                        exception       <= 1'b1;
                        rstatus         <= exc_code;
                        timeout_pending <= 1'b1;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                DONE: begin
                    state           <= timeout_pending ? DRAIN : IDLE;
                    count           <= '0;
                    timeout_pending <= 1'b0;
                end
                DRAIN: begin
                    if (md_resultRDY || count == COUNT_LAST) begin
                        state <= IDLE;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
